counter_arbiter: RTL and testbench

Shares one WIDTH-bit up-counter between NREQ requesters. Each requester posts a run length and holds a request. The block grants the counter to one requester at a time, counts from 0 up to length-1, then pulses a per-requester done. It sits between client logic and the counter datapath, and it drives the value bus and all sequencing itself.

---
 rtl/counter_arbiter.sv | 161 ++++++++++++++++
 tb/tb_counter_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// Shares one WIDTH-bit up-counter between NREQ requesters: round-robin grant, count 0..len-1, done pulse.
// Define COUNTER_ARB_FIXED_PRIORITY_EN to switch arbitration to fixed lowest-index-first priority.
module counter_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   localparam int OW   = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   len,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic [WIDTH-1:0]        value,
   output logic                    busy,
   output logic [OW-1:0]           owner,
   output logic [1:0]              o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Handshake: req is a level held by the client for the whole run; dropping
   // req[owner] while counting aborts the run without a done pulse.

   state_t           r_state;
   logic [OW-1:0]    r_ptr;
   logic [WIDTH-1:0] r_len_q;

   state_t           w_state_nxt;
   logic [OW-1:0]    w_ptr_nxt;
   logic [WIDTH-1:0] w_len_nxt;
   logic [NREQ-1:0]  w_gnt_nxt;
   logic [NREQ-1:0]  w_done_nxt;
   logic [WIDTH-1:0] w_value_nxt;
   logic             w_busy_nxt;
   logic [OW-1:0]    w_owner_nxt;

   logic [OW-1:0]    w_start;
   logic [OW-1:0]    w_winner;
   logic             w_found;
   int               w_idx;
   logic [WIDTH-1:0] w_len_sel;
   logic [NREQ-1:0]  w_win_onehot;
   logic [NREQ-1:0]  w_own_onehot;
   logic [WIDTH-1:0] w_last;
   logic [OW-1:0]    w_owner_inc;

`ifdef COUNTER_ARB_FIXED_PRIORITY_EN
   assign w_start = '0;
`else
   assign w_start = r_ptr;
`endif

   // Circular search starting at w_start; first asserted request wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = int'(w_start) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (!w_found && req[OW'(w_idx)]) begin
            w_found  = 1'b1;
            w_winner = OW'(w_idx);
         end
      end
   end

   always_comb begin
      w_len_sel    = '0;
      w_win_onehot = '0;
      w_own_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_winner == OW'(i)) begin
            w_len_sel       = len[i*WIDTH +: WIDTH];
            w_win_onehot[i] = 1'b1;
         end
         if (owner == OW'(i)) w_own_onehot[i] = 1'b1;
      end
   end

   // len_q == 0 makes the terminal value all-ones, giving a full 2^WIDTH run.
   assign w_last      = r_len_q - WIDTH'(1);
   assign w_owner_inc = (owner == OW'(NREQ-1)) ? '0 : owner + OW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_len_nxt   = r_len_q;
      w_gnt_nxt   = gnt;
      w_done_nxt  = '0;
      w_value_nxt = value;
      w_busy_nxt  = busy;
      w_owner_nxt = owner;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_len_nxt   = w_len_sel;
               w_owner_nxt = w_winner;
               w_gnt_nxt   = w_win_onehot;
               w_value_nxt = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_COUNT;
            end
         end
         S_COUNT: begin
            if (!req[owner]) begin
               w_gnt_nxt   = '0;
               w_busy_nxt  = 1'b0;
               w_ptr_nxt   = w_owner_inc;
               w_state_nxt = S_IDLE;
            end else if (value == w_last) begin
               w_gnt_nxt   = '0;
               w_done_nxt  = w_own_onehot;
               w_state_nxt = S_DONE;
            end else begin
               w_value_nxt = value + WIDTH'(1);
            end
         end
         S_DONE: begin
            w_busy_nxt  = 1'b0;
            w_ptr_nxt   = w_owner_inc;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_len_q <= '0;
         gnt     <= '0;
         done    <= '0;
         value   <= '0;
         busy    <= 1'b0;
         owner   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_len_q <= w_len_nxt;
         gnt     <= w_gnt_nxt;
         done    <= w_done_nxt;
         value   <= w_value_nxt;
         busy    <= w_busy_nxt;
         owner   <= w_owner_nxt;
      end
   end

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: transaction-level model of grant order and run timing.
module tb_counter_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] len;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic [WIDTH-1:0]      value;
   logic                  busy;
   logic [1:0]            owner;
   logic [1:0]            dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int m_ptr    = 0;
   int lens[NREQ];

   counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .req(req), .len(len), .gnt(gnt), .done(done),
      .value(value), .busy(busy), .owner(owner), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_len();
      for (int i = 0; i < NREQ; i++) len[i*WIDTH +: WIDTH] = lens[i][WIDTH-1:0];
   endtask

   // Expected winner from the round-robin rule (or fixed priority when configured).
   function automatic int pick(input logic [NREQ-1:0] r);
`ifdef COUNTER_ARB_FIXED_PRIORITY_EN
      for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
      for (int k = 0; k < NREQ; k++) if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
      return -1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = '0;
      @(negedge clk);
      reset = 1'b0;
      m_ptr = 0;
   endtask

   // Called at a negedge with req already driven while IDLE; checks one full run.
   task automatic run_grant(input int w, input int l);
      int n;
      logic [NREQ-1:0] oh;
      logic [NREQ-1:0] pat;
      n   = (l == 0) ? 256 : l;
      oh  = '0;
      oh[w] = 1'b1;
      pat = req;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         n_checks++;
         if (gnt !== oh || value !== WIDTH'(k) || busy !== 1'b1 || done !== '0 || owner !== 2'(w)) begin
            n_errors++;
            $display("FAIL run_count w=%0d k=%0d: gnt=%b value=%0d busy=%b done=%b owner=%0d, want gnt=%b value=%0d busy=1 done=0 owner=%0d",
                     w, k, gnt, value, busy, done, owner, oh, k, w);
         end
         len = NREQ*WIDTH'($urandom);
         req = NREQ'($urandom) | oh;
      end
      @(negedge clk);
      n_checks++;
      if (gnt !== '0 || done !== oh || value !== WIDTH'(n-1) || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL run_done w=%0d: gnt=%b done=%b value=%0d busy=%b, want gnt=0 done=%b value=%0d busy=1",
                  w, gnt, done, value, busy, oh, n-1);
      end
      @(negedge clk);
      n_checks++;
      if (gnt !== '0 || done !== '0 || value !== WIDTH'(n-1) || busy !== 1'b0 || owner !== 2'(w)) begin
         n_errors++;
         $display("FAIL run_idle w=%0d: gnt=%b done=%b value=%0d busy=%b owner=%0d, want 0 0 %0d 0 %0d",
                  w, gnt, done, value, busy, owner, n-1, w);
      end
      req = pat;
      drive_len();
      m_ptr = (w + 1) % NREQ;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         req = NREQ'($urandom);
         len = NREQ*WIDTH'($urandom);
         @(negedge clk);
         n_checks++;
         if (gnt !== '0 || done !== '0 || value !== '0 || busy !== 1'b0 || owner !== '0) begin
            n_errors++;
            $display("FAIL reset_state c=%0d: gnt=%b done=%b value=%0d busy=%b owner=%0d, want all 0",
                     c, gnt, done, value, busy, owner);
         end
      end
      req   = '0;
      reset = 1'b0;
      m_ptr = 0;
   endtask

   task automatic test_single();
      lens[2] = 5;
      drive_len();
      req = 4'b0100;
      run_grant(pick(req), lens[2]);
      req = '0;
   endtask

   task automatic test_idle_hold();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (gnt !== '0 || done !== '0 || busy !== 1'b0 || value !== 8'd4 || owner !== 2'd2) begin
            n_errors++;
            $display("FAIL idle_hold c=%0d: gnt=%b done=%b busy=%b value=%0d owner=%0d, want 0 0 0 4 2",
                     c, gnt, done, busy, value, owner);
         end
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < NREQ; i++) lens[i] = 3;
      drive_len();
      req = 4'b1111;
      for (int g = 0; g < 5; g++) run_grant(pick(req), 3);
      req = '0;
   endtask

   task automatic test_random();
      int w;
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < NREQ; i++) lens[i] = $urandom_range(1, 8);
         drive_len();
         req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         w = pick(req);
         run_grant(w, lens[w]);
      end
      req = '0;
   endtask

   task automatic test_wrap();
      lens[0] = 0;
      drive_len();
      req = 4'b0001;
      run_grant(pick(req), 0);
      req = '0;
   endtask

   task automatic test_abort();
      do_reset();
      lens[1] = 10;
      lens[3] = 2;
      drive_len();
      req = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (gnt !== 4'b0010 || value !== WIDTH'(k)) begin
            n_errors++;
            $display("FAIL abort_count k=%0d: gnt=%b value=%0d, want 0010 %0d", k, gnt, value, k);
         end
      end
      req = 4'b1000;
      @(negedge clk);
      n_checks++;
      if (gnt !== '0 || busy !== 1'b0 || done !== '0 || value !== 8'd3 || owner !== 2'd1) begin
         n_errors++;
         $display("FAIL abort_idle: gnt=%b busy=%b done=%b value=%0d owner=%0d, want 0 0 0 3 1",
                  gnt, busy, done, value, owner);
      end
      m_ptr = 2;
      run_grant(pick(req), lens[3]);
      req = '0;
   endtask

   task automatic test_abort_precedence();
      do_reset();
      lens[1] = 4;
      drive_len();
      req = 4'b0010;
      for (int k = 0; k < 4; k++) @(negedge clk);
      req = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (gnt !== '0 || busy !== 1'b0 || done !== '0 || value !== 8'd3) begin
            n_errors++;
            $display("FAIL abort_over_terminal c=%0d: gnt=%b busy=%b done=%b value=%0d, want 0 0 0 3",
                     c, gnt, busy, done, value);
         end
      end
      m_ptr = 2;
   endtask

   task automatic test_reset_mid_run();
      lens[2] = 20;
      drive_len();
      req = 4'b0100;
      for (int k = 0; k < 8; k++) @(negedge clk);
      n_checks++;
      if (value !== 8'd7 || gnt !== 4'b0100) begin
         n_errors++;
         $display("FAIL midrun_pre: value=%0d gnt=%b, want 7 0100", value, gnt);
      end
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (gnt !== '0 || done !== '0 || value !== '0 || busy !== 1'b0 || owner !== '0) begin
            n_errors++;
            $display("FAIL midrun_reset c=%0d: gnt=%b done=%b value=%0d busy=%b owner=%0d, want all 0",
                     c, gnt, done, value, busy, owner);
         end
         req = 4'b1111;
      end
      reset = 1'b0;
      m_ptr = 0;
      lens[0] = 3;
      lens[3] = 3;
      drive_len();
      req = 4'b1001;
      run_grant(pick(req), 3);
      req = '0;
   endtask

   task automatic test_priority_mode();
      int w;
      do_reset();
      for (int i = 0; i < NREQ; i++) lens[i] = 2;
      drive_len();
      req = 4'b1001;
      for (int g = 0; g < 3; g++) begin
         w = pick(req);
         run_grant(w, 2);
      end
      req = '0;
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      len   = '0;
      for (int i = 0; i < NREQ; i++) lens[i] = 1;
      test_reset();
      test_single();
      test_idle_hold();
      test_round_robin();
      test_random();
      test_wrap();
      test_abort();
      test_abort_precedence();
      test_reset_mid_run();
      test_priority_mode();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
